sha256_msg_schedule: RTL and testbench

Message-schedule stage of the SHA-256 datapath. It accepts one 512-bit padded message block over a valid/ready handshake and emits the schedule words W[0]..W[ROUNDS-1], one word per accepted beat. The compression-round stage consumes these words alongside the K constant stream. Expansion uses a 16-word sliding window and the small-sigma functions s0/s1.

---
 rtl/sha256_pkg.sv | 56 +++++
 rtl/sha256_msg_schedule_if.sv | 36 +++
 rtl/sha256_w_next.sv | 43 ++++
 rtl/sha256_msg_schedule.sv | 136 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Definitions shared across the SHA-256 datapath (message schedule and round
// stage):
//   - word, block and window sizes, and the default round count
//   - the schedule FSM state type
//   - the initial hash values and the K round-constant table
//   - a helper that extracts big-endian word i from a 512-bit block
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int SHA256_WORD_W  = 32;
  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_ROUNDS  = 64;
  localparam int SHA256_WIN     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Initial hash value H(0).
  localparam logic [SHA256_WORD_W-1:0] SHA256_H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants K[0..63], consumed by the round stage in step with W[t].
  localparam logic [SHA256_WORD_W-1:0] SHA256_K [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Word 0 sits in the top 32 bits of the block (big-endian word order).
  function automatic logic [SHA256_WORD_W-1:0] blk_word(
    input logic [SHA256_BLOCK_W-1:0] blk,
    input int                        i
  );
    return blk[SHA256_BLOCK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W];
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_if
// Bundles the two streams of the message-schedule stage:
//   blk_*  : 512-bit padded block in (valid/ready)
//   w_*    : schedule word W[w_idx] out (valid/ready), w_last on the final word
//   busy   : schedule is emitting words for a block
// Modports:
//   slave  : the schedule stage itself
//   master : the surrounding logic (block source + word consumer)
// -----------------------------------------------------------------------------
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic                      blk_valid;
  logic                      blk_ready;
  logic [SHA256_BLOCK_W-1:0] blk_data;

  logic                      w_valid;
  logic                      w_ready;
  logic [SHA256_WORD_W-1:0]  w_data;
  logic [5:0]                w_idx;
  logic                      w_last;

  logic                      busy;

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last, busy
  );

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last, busy
  );

endinterface

// File: rtl/sha256_w_next.sv
// -----------------------------------------------------------------------------
// s_sigma_zero / s_sigma_one / sha256_w_next
// Purely combinational schedule-word expansion.
//   s_sigma_zero : y = ROTR7(x)  ^ ROTR18(x) ^ SHR3(x)
//   s_sigma_one  : y = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
//   sha256_w_next: next = s1(w14) + w9 + s0(w1) + w0 (mod 2^32)
// where w0/w1/w9/w14 are taps of the 16-word window holding W[t..t+15], so
// next is W[t+16].
// -----------------------------------------------------------------------------
module s_sigma_zero (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

module s_sigma_one (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] w0,
  input  logic [SHA256_WORD_W-1:0] w1,
  input  logic [SHA256_WORD_W-1:0] w9,
  input  logic [SHA256_WORD_W-1:0] w14,
  output logic [SHA256_WORD_W-1:0] next
);

  logic [SHA256_WORD_W-1:0] sig0;
  logic [SHA256_WORD_W-1:0] sig1;

  s_sigma_zero u_s0 (.x(w1),  .y(sig0));
  s_sigma_one  u_s1 (.x(w14), .y(sig1));

  // 32-bit result width drops the carries out of bit 31.
  assign next = sig1 + w9 + sig0 + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// Message-schedule stage of the SHA-256 datapath. Accepts one padded 512-bit
// block and emits W[0..ROUNDS-1], one word per accepted beat.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : sha256_msg_schedule_if.slave
//            blk_valid/blk_ready/blk_data   block in
//            w_valid/w_ready/w_data/w_idx/w_last   word out
//            busy                           high while emitting (RUN)
//
// Operation: in IDLE the block is loaded into a 16-word window. In RUN the
// window head is presented as W[t]; every accepted beat shifts the window by
// one and appends the freshly expanded word, so the head becomes W[t+1].
// All outputs come straight from flops: w_ready only steers the next state.
// Throughput is one word per cycle; one IDLE cycle separates blocks.
// -----------------------------------------------------------------------------
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS  // 16..64; < 64 for debug only
) (
  input  logic                  clk,
  input  logic                  rst,
  sha256_msg_schedule_if.slave  bus
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t                   state_q,     state_d;
  logic [SHA256_WORD_W-1:0] win_q [SHA256_WIN];
  logic [SHA256_WORD_W-1:0] win_d [SHA256_WIN];
  logic [5:0]               t_q,         t_d;
  logic                     w_valid_q,   w_valid_d;
  logic                     blk_ready_q, blk_ready_d;
  logic                     w_last_q,    w_last_d;
  logic                     busy_q,      busy_d;

  logic [SHA256_WORD_W-1:0] w_next;

  sha256_w_next u_w_next (
    .w0   (win_q[0]),
    .w1   (win_q[1]),
    .w9   (win_q[9]),
    .w14  (win_q[14]),
    .next (w_next)
  );

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through
    // the case below can leave it unassigned and infer a latch.
    state_d     = state_q;
    win_d       = win_q;
    t_d         = t_q;
    w_valid_d   = w_valid_q;
    blk_ready_d = blk_ready_q;
    w_last_d    = w_last_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        // blk_ready is high throughout IDLE, so blk_valid alone is the handshake.
        if (bus.blk_valid) begin
          for (int i = 0; i < SHA256_WIN; i++) begin
            win_d[i] = blk_word(bus.blk_data, i);
          end
          t_d         = '0;
          w_valid_d   = 1'b1;
          blk_ready_d = 1'b0;
          busy_d      = 1'b1;
          w_last_d    = 1'b0;  // ROUNDS >= 16, so W[0] is never the last word
          state_d     = RUN;
        end
      end

      RUN: begin
        if (bus.w_ready) begin
          if (t_q == LAST_IDX) begin
            // Final word taken: back to IDLE, t never wraps past LAST_IDX.
            t_d         = '0;
            w_valid_d   = 1'b0;
            blk_ready_d = 1'b1;
            busy_d      = 1'b0;
            w_last_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < SHA256_WIN - 1; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[SHA256_WIN-1] = w_next;
            t_d      = t_q + 6'd1;
            w_last_d = (t_q + 6'd1 == LAST_IDX);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      w_valid_q   <= 1'b0;
      blk_ready_q <= 1'b1;
      w_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the window is cleared on reset because its head drives w_data
      // directly and w_data must read zero out of reset.
      for (int i = 0; i < SHA256_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its _d input, independent of statement order.
      state_q     <= state_d;
      t_q         <= t_d;
      w_valid_q   <= w_valid_d;
      blk_ready_q <= blk_ready_d;
      w_last_q    <= w_last_d;
      busy_q      <= busy_d;
      for (int i = 0; i < SHA256_WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_data    = win_q[0];
  assign bus.w_idx     = t_q;
  assign bus.w_last    = w_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Self-checking bench for sha256_msg_schedule. Two instances: ROUNDS=64 and
// ROUNDS=16, selected by sel16. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge. Expected words come from a
// reference schedule written in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16]
// form plus a table of known "abc" schedule values.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule;
  import sha256_pkg::*;

  localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] JUNK_BLK = {16{32'hA5A55A5A}};

  typedef struct {
    int          idx;
    logic [31:0] w;
  } spot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         tb_blk_valid = 1'b0;
  logic         tb_w_ready   = 1'b0;
  logic [511:0] tb_blk_data  = '0;
  logic         sel16        = 1'b0;

  sha256_msg_schedule_if ifc ();
  sha256_msg_schedule_if if16 ();

  assign ifc.blk_valid  = tb_blk_valid & ~sel16;
  assign ifc.blk_data   = tb_blk_data;
  assign ifc.w_ready    = tb_w_ready & ~sel16;
  assign if16.blk_valid = tb_blk_valid & sel16;
  assign if16.blk_data  = tb_blk_data;
  assign if16.w_ready   = tb_w_ready & sel16;

  sha256_msg_schedule #(.ROUNDS(64)) u_dut   (.clk(clk), .rst(rst), .bus(ifc));
  sha256_msg_schedule #(.ROUNDS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  logic        o_valid, o_ready, o_last, o_busy;
  logic [31:0] o_data;
  logic [5:0]  o_idx;
  assign o_valid = sel16 ? if16.w_valid   : ifc.w_valid;
  assign o_ready = sel16 ? if16.blk_ready : ifc.blk_ready;
  assign o_last  = sel16 ? if16.w_last    : ifc.w_last;
  assign o_busy  = sel16 ? if16.busy      : ifc.busy;
  assign o_data  = sel16 ? if16.w_data    : ifc.w_data;
  assign o_idx   = sel16 ? if16.w_idx     : ifc.w_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
  endtask

  // Called on a falling edge. Offers the block, waits (bounded) for blk_ready,
  // and returns on the falling edge where W[0] must already be visible.
  task automatic accept(input logic [511:0] b, input bit hold);
    int guard = 0;
    tb_blk_data  = b;
    tb_blk_valid = 1'b1;
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", o_ready, 1);
    @(negedge clk);
    if (!hold) tb_blk_valid = 1'b0;
    tb_blk_data = JUNK_BLK;
    check("w0_latency_valid", o_valid, 1);
    check("w0_latency_idx", o_idx, 0);
  endtask

  // Consumes words until 'stop' handshakes have happened. mode 0: always
  // ready; mode 1: random ready with a 10-cycle stall while W[16] is shown.
  // Returns on the falling edge after the last handshake, w_ready low.
  task automatic collect(input int rounds, input int mode, input int stop);
    int          cnt = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          stalled = 1'b0;
    logic        rdy;
    logic [31:0] sd;
    logic [5:0]  si;
    logic        sl;
    while (cnt < stop && cyc < 4000) begin
      check("run_valid", o_valid, 1);
      check("run_busy", o_busy, 1);
      check("run_blk_ready", o_ready, 0);
      if (stalled) begin
        check("stall_data", o_data, sd);
        check("stall_idx", o_idx, si);
        check("stall_last", o_last, sl);
      end
      if (mode == 1 && cnt == 16 && stall < 10) begin
        rdy = 1'b0;
        stall++;
      end else if (mode == 1) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      tb_w_ready = rdy;
      if (rdy) begin
        check("w_data", o_data, exp_w[cnt]);
        check("w_idx", o_idx, cnt);
        check("w_last", o_last, (cnt == rounds - 1));
        got_w[cnt] = o_data;
        cnt++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        sd = o_data;
        si = o_idx;
        sl = o_last;
      end
      @(negedge clk);
      cyc++;
    end
    tb_w_ready = 1'b0;
    check("word_count", cnt, stop);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_w_valid"}, o_valid, 0);
    check({tag, "_blk_ready"}, o_ready, 1);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  spot_t       abc_spots [7];
  logic [511:0] blk_b;

  initial begin
    abc_spots = '{
      '{0,  32'h61626380},
      '{1,  32'h00000000},
      '{15, 32'h00000018},
      '{16, 32'h61626380},
      '{17, 32'h000F0000},
      '{18, 32'h7DA86405},
      '{63, 32'h12B1EDEB}
    };
    for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h89ABCDEF ^ (32'h01010101 * (i + 1));

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_w_idx", o_idx, 0);
    check("reset_w_last", o_last, 0);
    check("reset_w_data", o_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // "abc" block, w_ready held high
    build_model(ABC_BLK);
    accept(ABC_BLK, 1'b0);
    collect(64, 0, 64);
    check_idle("abc_end");
    for (int i = 0; i < 7; i++) check("abc_spot", got_w[abc_spots[i].idx], abc_spots[i].w);

    // All-zero block
    build_model('0);
    accept('0, 1'b0);
    collect(64, 0, 64);
    check_idle("zero_end");

    // "abc" block under random backpressure
    build_model(ABC_BLK);
    accept(ABC_BLK, 1'b0);
    collect(64, 1, 64);
    check_idle("stall_end");
    for (int i = 0; i < 7; i++) check("stall_spot", got_w[abc_spots[i].idx], abc_spots[i].w);

    // Back-to-back blocks with blk_valid held; blk_data changes during RUN
    build_model(ABC_BLK);
    accept(ABC_BLK, 1'b1);
    tb_blk_data = blk_b;
    collect(64, 0, 64);
    check("b2b_bubble_valid", o_valid, 0);
    check("b2b_bubble_ready", o_ready, 1);
    @(negedge clk);
    tb_blk_valid = 1'b0;
    tb_blk_data  = JUNK_BLK;
    check("b2b_second_valid", o_valid, 1);
    check("b2b_second_idx", o_idx, 0);
    build_model(blk_b);
    collect(64, 0, 64);
    check_idle("b2b_end");

    // Reset while W[20] is on the output
    build_model(ABC_BLK);
    accept(ABC_BLK, 1'b0);
    collect(64, 0, 20);
    check("pre_rst_idx", o_idx, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_idx", o_idx, 0);
    tb_w_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_words", o_valid, 0);
    end
    tb_w_ready = 1'b0;
    accept(ABC_BLK, 1'b0);
    collect(64, 0, 64);
    check_idle("rst_fresh_end");

    // ROUNDS=16 instance: the words are exactly the block words
    sel16 = 1'b1;
    @(negedge clk);
    build_model(ABC_BLK);
    accept(ABC_BLK, 1'b0);
    collect(16, 0, 16);
    check_idle("r16_end");
    for (int i = 0; i < 16; i++) check("r16_word", got_w[i], ABC_BLK[511-32*i -: 32]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
